// File: rtl/pong_pkg.sv
// Shared Pong encodings: game state, keyboard and paddle direction codes.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } game_state_t;

    localparam logic [1:0] KEY_DOWN = 2'b01;
    localparam logic [1:0] KEY_UP   = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10
    } dir_t;

endpackage

// File: rtl/paddle_tick_div.sv
// Free-running move-tick divider: one tick per 2^DIV_W enabled cycles.
module paddle_tick_div #(
    parameter int unsigned DIV_W = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = enable && (&cnt);

endmodule

// File: rtl/paddle_ctrl_gen2.sv
// Paddle controller: keyboard or ball-tracking vertical motion with
// hold-to-accelerate stepping, clamped to the playfield.
module paddle_ctrl_gen2
    import pong_pkg::*;
#(
    parameter int unsigned Y_W         = 10,
    parameter int unsigned X_W         = 10,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PAD_H       = 56,
    parameter int unsigned HOME_Y      = 232,
    parameter int unsigned X_LEFT      = 0,
    parameter int unsigned X_RIGHT     = 614,
    parameter int unsigned DIV_W       = 19,
    parameter int unsigned ACCEL_TICKS = 4,
    parameter int unsigned MAX_STEP    = 4,
    parameter int unsigned DEADBAND    = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     state,
    input  logic           mode,
    input  logic [1:0]     keyboard,
    input  logic [Y_W-1:0] ballY,
    input  logic           player,
    output logic [X_W-1:0] posX,
    output logic [Y_W-1:0] posY,
    output logic [1:0]     dir,
    output logic           at_limit
);

    localparam int unsigned Y_MAX    = SCREEN_H - PAD_H;
    localparam int unsigned HALF_PAD = PAD_H / 2;
    localparam int unsigned WY       = Y_W + 1;
    localparam int unsigned STEP_W   = $clog2(MAX_STEP + 1);
    localparam int unsigned HOLD_W   = $clog2(ACCEL_TICKS);

    game_state_t       gs;
    logic              idle;
    logic              tick;

    logic [Y_W-1:0]    pos_q, pos_d;
    dir_t              dir_q, dir_d;
    dir_t              last_q, last_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    dir_t              d_c;
    logic [WY-1:0]     pos_w;
    logic [WY-1:0]     tgt_raw;
    logic [WY-1:0]     tgt;
    logic [WY-1:0]     mv_w;
    logic [WY-1:0]     sum_w;

    assign gs    = game_state_t'(state);
    assign idle  = (gs == ST_START) || (gs == ST_DONE);
    assign pos_w = {1'b0, pos_q};

    paddle_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (idle),
        .enable (!idle),
        .tick   (tick)
    );

    // Ball-centred target; the extra MSB flags ballY above the half-paddle.
    assign tgt_raw = {1'b0, ballY} - WY'(HALF_PAD);

    always_comb begin
        tgt = tgt_raw;
        if (tgt_raw[WY-1]) begin
            tgt = '0;
        end else if (tgt_raw > WY'(Y_MAX)) begin
            tgt = WY'(Y_MAX);
        end
    end

    always_comb begin
        d_c = DIR_NONE;
        if (mode) begin
            if (pos_w + WY'(DEADBAND) < tgt) begin
                d_c = DIR_DOWN;
            end else if (pos_w > tgt + WY'(DEADBAND)) begin
                d_c = DIR_UP;
            end
        end else begin
            case (keyboard)
                KEY_DOWN: d_c = DIR_DOWN;
                KEY_UP:   d_c = DIR_UP;
                default:  d_c = DIR_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= Y_W'(HOME_Y);
            dir_q  <= DIR_NONE;
            last_q <= DIR_NONE;
            step_q <= STEP_W'(1);
            hold_q <= '0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            last_q <= last_d;
            step_q <= step_d;
            hold_q <= hold_d;
        end
    end

    // Per-tick step/acceleration update and clamped move.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        last_d = last_q;
        step_d = step_q;
        hold_d = hold_q;
        mv_w   = '0;
        sum_w  = '0;

        if (idle) begin
            pos_d  = Y_W'(HOME_Y);
            dir_d  = DIR_NONE;
            last_d = DIR_NONE;
            step_d = STEP_W'(1);
            hold_d = '0;
        end else if (tick) begin
            dir_d  = d_c;
            last_d = d_c;
            if (d_c == DIR_NONE) begin
                step_d = STEP_W'(1);
                hold_d = '0;
            end else begin
                if (d_c != last_q) begin
                    mv_w   = WY'(1);
                    step_d = STEP_W'(1);
                    hold_d = HOLD_W'(1);
                end else begin
                    mv_w = WY'(step_q);
                    if (hold_q == HOLD_W'(ACCEL_TICKS - 1)) begin
                        hold_d = '0;
                        if (step_q < STEP_W'(MAX_STEP)) begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end

                if (d_c == DIR_DOWN) begin
                    sum_w = pos_w + mv_w;
                    pos_d = (sum_w > WY'(Y_MAX)) ? Y_W'(Y_MAX) : Y_W'(sum_w);
                end else begin
                    sum_w = pos_w - mv_w;
                    pos_d = (pos_w >= mv_w) ? Y_W'(sum_w) : '0;
                end
            end
        end
    end

    assign posY     = pos_q;
    assign dir      = dir_q;
    assign posX     = player ? X_W'(X_RIGHT) : X_W'(X_LEFT);
    assign at_limit = (pos_q == '0) || (pos_q == Y_W'(Y_MAX));

endmodule

// File: tb/tb_paddle_ctrl_gen2.sv
// Bench for paddle_ctrl_gen2: directed scenarios plus random stimulus
// checked every cycle against an integer reference model.
module tb_paddle_ctrl_gen2;

    localparam int PERIOD = 16;
    localparam int YMAX   = 424;
    localparam int HOME   = 232;
    localparam int HALF   = 28;
    localparam int ACC    = 4;
    localparam int MAXS   = 4;
    localparam int DB     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic       mode;
    logic [1:0] keyboard;
    logic [9:0] ballY;
    logic       player;
    logic [9:0] posX;
    logic [9:0] posY;
    logic [1:0] dir;
    logic       at_limit;

    int n_checks = 0;
    int n_errors = 0;

    int m_pos, m_step, m_hold, m_last, m_dir, m_cnt;
    bit m_ticked;

    paddle_ctrl_gen2 #(
        .DIV_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .mode     (mode),
        .keyboard (keyboard),
        .ballY    (ballY),
        .player   (player),
        .posX     (posX),
        .posY     (posY),
        .dir      (dir),
        .at_limit (at_limit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock edge of paddle behaviour from current inputs.
    task automatic model_step();
        int d, tgt, amt;
        m_ticked = 1'b0;
        if (rst || state == 2'd0 || state == 2'd3) begin
            m_pos = HOME; m_step = 1; m_hold = 0; m_last = 0; m_dir = 0; m_cnt = 0;
        end else begin
            if (m_cnt == PERIOD - 1) begin
                m_ticked = 1'b1;
                if (mode) begin
                    tgt = int'(ballY) - HALF;
                    if (tgt < 0) tgt = 0;
                    if (tgt > YMAX) tgt = YMAX;
                    d = (m_pos + DB < tgt) ? 1 : ((m_pos > tgt + DB) ? 2 : 0);
                end else begin
                    d = (keyboard == 2'b01) ? 1 : ((keyboard == 2'b10) ? 2 : 0);
                end
                amt = 0;
                if (d == 0) begin
                    m_step = 1; m_hold = 0;
                end else if (d != m_last) begin
                    amt = 1; m_step = 1; m_hold = 1;
                end else begin
                    amt = m_step;
                    m_hold = m_hold + 1;
                    if (m_hold == ACC) begin
                        m_hold = 0;
                        m_step = (m_step + 1 > MAXS) ? MAXS : m_step + 1;
                    end
                end
                if (d == 1) m_pos = (m_pos + amt > YMAX) ? YMAX : m_pos + amt;
                if (d == 2) m_pos = (m_pos - amt < 0) ? 0 : m_pos - amt;
                m_last = d;
                m_dir  = d;
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("posY", int'(posY), m_pos);
        chk("dir", int'(dir), m_dir);
        chk("at_limit", int'(at_limit), (m_pos == 0 || m_pos == YMAX) ? 1 : 0);
        chk("posX", int'(posX), player ? 614 : 0);
    endtask

    task automatic run_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            int k = 0;
            do begin
                cyc();
                k++;
            end while (!m_ticked && k < 64);
            if (!m_ticked) chk("tick_timeout", 0, 1);
        end
    endtask

    int exp_seq [9];

    initial begin
        exp_seq = '{233, 234, 235, 236, 238, 240, 242, 244, 247};
        rst = 1'b1; state = 2'd2; mode = 1'b0; keyboard = 2'b01; ballY = '0; player = 1'b0;
        cyc();
        chk("reset_posY", int'(posY), 232);
        chk("reset_dir", int'(dir), 0);

        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_ticks(1);
            chk("accel_posY", int'(posY), exp_seq[i]);
            chk("accel_dir", int'(dir), 1);
        end

        run_ticks(60);
        chk("bottom_posY", int'(posY), 424);
        chk("bottom_limit", int'(at_limit), 1);
        run_ticks(2);
        chk("bottom_hold", int'(posY), 424);
        keyboard = 2'b10;
        run_ticks(1);
        chk("reverse_one", int'(posY), 423);

        run_ticks(140);
        chk("top_posY", int'(posY), 0);
        chk("top_limit", int'(at_limit), 1);
        keyboard = 2'b11;
        run_ticks(1);
        chk("idle_key_dir", int'(dir), 0);
        chk("idle_key_pos", int'(posY), 0);

        state = 2'd0;
        cyc();
        chk("start_home", int'(posY), 232);
        state = 2'd2; mode = 1'b1; ballY = 10'd100;
        run_ticks(60);
        chk("auto_settle", (int'(posY) >= 70 && int'(posY) <= 74) ? 1 : 0, 1);
        chk("auto_dir", int'(dir), 0);
        ballY = 10'd10;
        run_ticks(60);
        chk("auto_clamp0", (int'(posY) <= 2) ? 1 : 0, 1);

        state = 2'd0; mode = 1'b0; keyboard = 2'b01;
        cyc();
        state = 2'd1;
        run_ticks(8);
        state = 2'd3;
        cyc();
        chk("done_home", int'(posY), 232);
        state = 2'd2;
        run_ticks(1);
        chk("restart_one", int'(posY), 233);

        run_ticks(5);
        rst = 1'b1;
        cyc();
        chk("rst_posY", int'(posY), 232);
        chk("rst_dir", int'(dir), 0);
        rst = 1'b0;
        player = 1'b1;
        cyc();
        chk("posX_right", int'(posX), 614);
        player = 1'b0;
        cyc();
        chk("posX_left", int'(posX), 0);

        repeat (6000) begin
            rst = ($urandom_range(0, 499) == 0);
            if (state == 2'd0 || state == 2'd3) begin
                if ($urandom_range(0, 9) == 0) state = 2'd2;
            end else if ($urandom_range(0, 299) == 0) begin
                state = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 149) == 0) mode = ~mode;
            if ($urandom_range(0, 39) == 0) keyboard = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) ballY = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 63) == 0) player = ~player;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl_gen2.md
Name: paddle_ctrl_gen2

Overview:
Parametrised paddle controller for the Pong datapath. Moves one paddle vertically from keyboard input (manual mode) or by tracking the ball (auto mode), with hold-to-accelerate stepping and clamping to the playfield. Sits between the keyboard decoder / game FSM and the renderer / collision logic. Instantiated once per player.

Parameters:
Y_W, 10, width of vertical coordinates (posY, ballY)
X_W, 10, width of posX
SCREEN_H, 480, playfield height in pixels
PAD_H, 56, paddle height; Y_MAX = SCREEN_H - PAD_H = 424
HOME_Y, 232, paddle Y in START/DONE and after reset
X_LEFT, 0, posX when player = 0
X_RIGHT, 614, posX when player = 1
DIV_W, 19, tick divider width; one move tick per 2^DIV_W cycles
ACCEL_TICKS, 4, consecutive same-direction ticks per step increment (must be >= 2)
MAX_STEP, 4, maximum pixels per tick (>= 1)
DEADBAND, 2, auto-mode tolerance in pixels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
state  in  2  game state: START=00, SERVE=01, PLAY=10, DONE=11
mode  in  1  0 = manual (keyboard), 1 = auto (ball tracking)
keyboard  in  2  01 = down (+Y), 10 = up (-Y), 00/11 = no move
ballY  in  Y_W  ball top Y
player  in  1  side select
posX  out  X_W  combinational: player ? X_RIGHT : X_LEFT
posY  out  Y_W  registered paddle top Y
dir  out  2  registered direction applied on last tick: 00 none, 01 down, 10 up
at_limit  out  1  combinational: posY == 0 or posY == Y_MAX

Behaviour:
- Reset (rst=1 at posedge): posY=HOME_Y, div counter=0, step=1, hold=0, last_dir=none, dir=00. rst overrides all other inputs.
- START or DONE: same values as reset, applied on the next clock edge (idle/home); takes effect mid-hold or mid-acceleration.
- SERVE or PLAY: div counter increments every cycle and wraps. tick = 1 in the cycle when the counter is all ones. posY changes only on tick cycles.
- Direction D on tick:
  - Manual: from keyboard as coded above.
  - Auto: target = ballY - PAD_H/2, clamped to [0, Y_MAX]; use signed/one-bit-wider arithmetic, so ballY < PAD_H/2 gives target 0.
  - Auto: D = down if posY + DEADBAND < target; up if posY > target + DEADBAND; else none.
- Stepping on tick:
  - D = none: no move; step<=1, hold<=0.
  - D != last_dir: move 1 pixel; step<=1, hold<=1.
  - D == last_dir: move by step. If hold == ACCEL_TICKS-1: hold<=0, step<=min(step+1, MAX_STEP). Else hold<=hold+1.
  - Always: last_dir<=D and dir<=D.
- Clamping (computed in Y_W+1 bits):
  - Down: posY <= min(posY+step, Y_MAX).
  - Up: posY <= (posY >= step) ? posY-step : 0.
  - At a limit, a blocked move leaves posY unchanged but dir and acceleration still update.
- Mode change mid-play takes effect on the next tick. A direction change caused by it resets the step via the D != last_dir rule.
- Latency: posY updates on the clock edge ending the tick cycle.

Decomposition:
- Shared package pong_pkg holds:
  - state codes START/SERVE/PLAY/DONE
  - keyboard codes KEY_DOWN=01, KEY_UP=10
  - dir codes DIR_NONE/DIR_DOWN/DIR_UP
- Sub-module paddle_tick_div (parameter DIV_W):
  - inputs clk, rst, clear (START/DONE), enable
  - output tick
  - shared with the ball mover.

Test Plan:
- Run with DIV_W=4 (tick every 16 cycles). Reset, state=PLAY, manual, keyboard=01 held for 9 ticks (defaults, MAX_STEP=4) -> posY after each tick: 233,234,235,236,238,240,242,244,247; dir=01.
- posY=422 at step 3, keyboard=01 -> next tick posY=424, at_limit=1. Further ticks keep 424. Then keyboard=10 -> 423 (step reset to 1).
- Up from posY=1 at step 3 -> posY=0, at_limit=1. keyboard=11 on next tick -> no move, dir=00, step=1.
- Auto mode, posY=232, ballY=100 (target 72) -> moves up with acceleration. Once |posY-72| <= 2, dir=00 and posY holds. ballY=10 -> target clamps to 0.
- Mid-acceleration (step=3) switch state to START -> posY=232, step=1 on next edge. Back to PLAY -> first move is 1 pixel.
- rst asserted while state=PLAY and keyboard held -> posY=232, dir=00 next edge. player=1 -> posX=614, player=0 -> posX=0.
